tour_cmd_gen: RTL and testbench

Command initiator for the knight-tour robot: replays a computed tour as a sequence of move commands to the command processor. Each one-hot knight move becomes two commands, a vertical leg and then a horizontal leg with fanfare. The block waits for the processor's completion pulse before advancing and generates the 8-bit response byte for the UART. When no tour is active, it passes host UART commands straight through to the command processor.

---
 rtl/tour_cmd_gen_pkg.sv | 34 +++
 rtl/tour_cmd_gen_knight_move_decode.sv | 40 ++++
 rtl/tour_cmd_gen.sv | 105 ++++++++++
 tb/tb_tour_cmd_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tour_cmd_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tour_cmd_gen_pkg
// Description : Shared types and constants for the knight-tour command
//               initiator: FSM state encoding, command opcodes, headings and
//               UART response bytes.
// Revision    : 1.0  initial release
// ============================================================================
package tour_cmd_gen_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    VERT      = 3'd1,
    VERT_WAIT = 3'd2,
    HORZ      = 3'd3,
    HORZ_WAIT = 3'd4
  } state_t;

  // Command opcodes: plain move, and move followed by fanfare
  localparam logic [3:0] MOVE    = 4'h2;
  localparam logic [3:0] MOVE_FF = 4'h3;

  // Headings as understood by the command processor
  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  // Response bytes back to the host
  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;

endpackage : tour_cmd_gen_pkg
`default_nettype wire

// File: rtl/tour_cmd_gen_knight_move_decode.sv
`default_nettype none
// ============================================================================
// Module      : knight_move_decode
// Description : Combinational decode of a one-hot knight move into a vertical
//               leg and a horizontal leg, each as {heading, squares}. The
//               lowest set bit wins; an all-zero move gives zero-length legs
//               heading north and east.
// Revision    : 1.0  initial release
// ============================================================================
module knight_move_decode
  import tour_cmd_gen_pkg::*;
(
  input  logic [7:0] move,
  output logic [7:0] vert_hdg,
  output logic [3:0] vert_sq,
  output logic [7:0] horz_hdg,
  output logic [3:0] horz_sq
);

  // Priority decode of the move bits into two axis-aligned legs
  always_comb begin
    vert_hdg = HDG_N;
    vert_sq  = 4'd0;
    horz_hdg = HDG_E;
    horz_sq  = 4'd0;
    casez (move)
      8'b???????1: begin vert_hdg = HDG_N; vert_sq = 4'd2; horz_hdg = HDG_E; horz_sq = 4'd1; end
      8'b??????10: begin vert_hdg = HDG_N; vert_sq = 4'd2; horz_hdg = HDG_W; horz_sq = 4'd1; end
      8'b?????100: begin vert_hdg = HDG_N; vert_sq = 4'd1; horz_hdg = HDG_W; horz_sq = 4'd2; end
      8'b????1000: begin vert_hdg = HDG_S; vert_sq = 4'd1; horz_hdg = HDG_W; horz_sq = 4'd2; end
      8'b???10000: begin vert_hdg = HDG_S; vert_sq = 4'd2; horz_hdg = HDG_W; horz_sq = 4'd1; end
      8'b??100000: begin vert_hdg = HDG_S; vert_sq = 4'd2; horz_hdg = HDG_E; horz_sq = 4'd1; end
      8'b?1000000: begin vert_hdg = HDG_S; vert_sq = 4'd1; horz_hdg = HDG_E; horz_sq = 4'd2; end
      8'b10000000: begin vert_hdg = HDG_N; vert_sq = 4'd1; horz_hdg = HDG_E; horz_sq = 4'd2; end
      default:     begin vert_hdg = HDG_N; vert_sq = 4'd0; horz_hdg = HDG_E; horz_sq = 4'd0; end
    endcase
  end

endmodule : knight_move_decode
`default_nettype wire

// File: rtl/tour_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module      : tour_cmd_gen
// Description : Knight-tour command initiator. Replays a solved tour as
//               vertical/horizontal move command pairs, handshaking with the
//               command processor, and passes host UART commands through
//               while no tour is running.
// Revision    : 1.0  initial release
// ============================================================================
module tour_cmd_gen
  import tour_cmd_gen_pkg::*;
#(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  state_t     r_state;
  logic [7:0] w_vert_hdg;
  logic [3:0] w_vert_sq;
  logic [7:0] w_horz_hdg;
  logic [3:0] w_horz_sq;
  logic       w_last;

  knight_move_decode u_decode (
    .move     (move),
    .vert_hdg (w_vert_hdg),
    .vert_sq  (w_vert_sq),
    .horz_hdg (w_horz_hdg),
    .horz_sq  (w_horz_sq)
  );

  assign w_last = (mv_indx == LAST_IDX);

  // Tour sequencer: state and move index advance on processor handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      mv_indx <= 5'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_tour) begin
            mv_indx <= 5'd0;
            r_state <= VERT;
          end
        end
        VERT:      if (clr_cmd_rdy) r_state <= VERT_WAIT;
        VERT_WAIT: if (send_resp)   r_state <= HORZ;
        HORZ:      if (clr_cmd_rdy) r_state <= HORZ_WAIT;
        HORZ_WAIT: begin
          if (send_resp) begin
            if (w_last) begin
              r_state <= IDLE;
            end else begin
              mv_indx <= mv_indx + 5'd1;
              r_state <= VERT;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output mux: UART pass-through when idle, decoded move legs while touring
  always_comb begin
    cmd              = cmd_UART;
    cmd_rdy          = cmd_rdy_UART;
    clr_cmd_rdy_UART = clr_cmd_rdy;
    resp             = RESP_DONE;
    case (r_state)
      VERT, VERT_WAIT: begin
        cmd              = {MOVE, w_vert_hdg, w_vert_sq};
        cmd_rdy          = (r_state == VERT);
        clr_cmd_rdy_UART = 1'b0;
        resp             = RESP_BUSY;
      end
      HORZ, HORZ_WAIT: begin
        cmd              = {MOVE_FF, w_horz_hdg, w_horz_sq};
        cmd_rdy          = (r_state == HORZ);
        clr_cmd_rdy_UART = 1'b0;
        // The final leg's completion is reported to the host as done
        resp             = (r_state == HORZ_WAIT && w_last) ? RESP_DONE : RESP_BUSY;
      end
      default: ;
    endcase
  end

endmodule : tour_cmd_gen
`default_nettype wire

// File: tb/tb_tour_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_tour_cmd_gen
// Description : Directed self-checking bench for tour_cmd_gen.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tour_cmd_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  logic [7:0]  mem [0:23];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  assign move = (mv_indx < 5'd24) ? mem[mv_indx] : 8'h00;

  tour_cmd_gen #(.NUM_MOVES(24)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp)
  );

  // Expected command from knight displacement (dx east, dy north)
  function automatic logic [15:0] exp_cmd(input logic [7:0] m, input bit horiz);
    int dx, dy;
    dx = 0; dy = 0;
    if      (m[0]) begin dx =  1; dy =  2; end
    else if (m[1]) begin dx = -1; dy =  2; end
    else if (m[2]) begin dx = -2; dy =  1; end
    else if (m[3]) begin dx = -2; dy = -1; end
    else if (m[4]) begin dx = -1; dy = -2; end
    else if (m[5]) begin dx =  1; dy = -2; end
    else if (m[6]) begin dx =  2; dy = -1; end
    else if (m[7]) begin dx =  2; dy =  1; end
    if (horiz)
      exp_cmd = {4'h3, (dx > 0 || m == 8'h00) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
    else
      exp_cmd = {4'h2, (dy > 0 || m == 8'h00) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
  endfunction

  // Advance one clock; sample point is 2 time units after the rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic accept();
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0; #1;
  endtask

  task automatic respond();
    send_resp = 1'b1; tick(); send_resp = 1'b0; #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    cmd_rdy_UART = 1'b0; cmd_UART = 16'h0000;
    rst_n = 1'b0; #1;
    n_checks++; if (cmd_rdy !== 1'b0) begin n_errors++; $display("FAIL reset_cmd_rdy got=%b exp=0", cmd_rdy); end
    n_checks++; if (clr_cmd_rdy_UART !== 1'b0) begin n_errors++; $display("FAIL reset_clr_uart got=%b exp=0", clr_cmd_rdy_UART); end
    n_checks++; if (resp !== 8'hA5) begin n_errors++; $display("FAIL reset_resp got=%h exp=a5", resp); end
    n_checks++; if (mv_indx !== 5'd0) begin n_errors++; $display("FAIL reset_mv_indx got=%0d exp=0", mv_indx); end
    do_reset();
  endtask

  task automatic test_passthrough();
    cmd_UART = 16'h0000; cmd_rdy_UART = 1'b1; #1;
    n_checks++; if (cmd !== 16'h0000 || cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL pass_cmd got=%h/%b exp=0000/1", cmd, cmd_rdy); end
    n_checks++; if (resp !== 8'hA5) begin n_errors++; $display("FAIL pass_resp got=%h exp=a5", resp); end
    clr_cmd_rdy = 1'b1; #1;
    n_checks++; if (clr_cmd_rdy_UART !== 1'b1) begin n_errors++; $display("FAIL pass_clr got=%b exp=1", clr_cmd_rdy_UART); end
    clr_cmd_rdy = 1'b0; cmd_UART = 16'h1234; #1;
    n_checks++; if (cmd !== 16'h1234 || clr_cmd_rdy_UART !== 1'b0) begin n_errors++; $display("FAIL pass_cmd2 got=%h/%b exp=1234/0", cmd, clr_cmd_rdy_UART); end
    cmd_rdy_UART = 1'b0; #1;
  endtask

  task automatic test_single_moves();
    mem[0] = 8'h01; mem[1] = 8'h0C; mem[2] = 8'h00; mem[3] = 8'h10;
    start_tour = 1'b1; tick(); start_tour = 1'b0; #1;
    n_checks++; if (cmd !== 16'h2002 || cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL bit0_vert got=%h/%b exp=2002/1", cmd, cmd_rdy); end
    n_checks++; if (resp !== 8'h5A) begin n_errors++; $display("FAIL bit0_resp got=%h exp=5a", resp); end
    // send_resp before acceptance must not advance
    respond();
    n_checks++; if (cmd !== 16'h2002 || cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL early_resp got=%h/%b exp=2002/1", cmd, cmd_rdy); end
    accept();
    n_checks++; if (cmd !== 16'h2002 || cmd_rdy !== 1'b0) begin n_errors++; $display("FAIL vert_wait got=%h/%b exp=2002/0", cmd, cmd_rdy); end
    respond();
    n_checks++; if (cmd !== 16'h3BF1 || cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL bit0_horz got=%h/%b exp=3bf1/1", cmd, cmd_rdy); end
    accept();
    n_checks++; if (resp !== 8'h5A || cmd_rdy !== 1'b0) begin n_errors++; $display("FAIL horz_wait got=%h/%b exp=5a/0", resp, cmd_rdy); end
    respond();
    n_checks++; if (mv_indx !== 5'd1 || resp !== 8'h5A) begin n_errors++; $display("FAIL bit0_adv got=%0d/%h exp=1/5a", mv_indx, resp); end
    // multi-hot 0x0C: bit2 wins (-2,+1)
    n_checks++; if (cmd !== 16'h2001) begin n_errors++; $display("FAIL multi_vert got=%h exp=2001", cmd); end
    accept(); respond();
    n_checks++; if (cmd !== 16'h33F2) begin n_errors++; $display("FAIL multi_horz got=%h exp=33f2", cmd); end
    accept(); respond();
    // all-zero move
    n_checks++; if (cmd !== 16'h2000) begin n_errors++; $display("FAIL zero_vert got=%h exp=2000", cmd); end
    accept(); respond();
    n_checks++; if (cmd !== 16'h3BF0) begin n_errors++; $display("FAIL zero_horz got=%h exp=3bf0", cmd); end
    accept(); respond();
    // bit4 (-1,-2)
    n_checks++; if (cmd !== 16'h27F2) begin n_errors++; $display("FAIL bit4_vert got=%h exp=27f2", cmd); end
    accept(); respond();
    n_checks++; if (cmd !== 16'h33F1) begin n_errors++; $display("FAIL bit4_horz got=%h exp=33f1", cmd); end
    do_reset();
  endtask

  task automatic test_full_tour();
    int ncmd;
    int budget;
    for (int i = 0; i < 24; i++) mem[i] = 8'h01 << (i % 8);
    mem[9] = 8'hC0; mem[17] = 8'h00;
    cmd_UART = 16'hBEEF; cmd_rdy_UART = 1'b1;
    ncmd = 0;
    start_tour = 1'b1; tick(); start_tour = 1'b0; #1;
    for (int k = 0; k < 48; k++) begin
      budget = 0;
      while (cmd_rdy !== 1'b1 && budget < 20) begin tick(); budget++; end
      n_checks++; if (cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL tour_timeout cmd=%0d got=%b exp=1", k, cmd_rdy); end
      ncmd++;
      n_checks++;
      if (cmd !== exp_cmd(mem[k/2], (k % 2) == 1)) begin
        n_errors++; $display("FAIL tour_cmd k=%0d got=%h exp=%h", k, cmd, exp_cmd(mem[k/2], (k % 2) == 1));
      end
      n_checks++; if (clr_cmd_rdy_UART !== 1'b0) begin n_errors++; $display("FAIL tour_uart_clr k=%0d got=%b exp=0", k, clr_cmd_rdy_UART); end
      accept();
      n_checks++; if (clr_cmd_rdy_UART !== 1'b0) begin n_errors++; $display("FAIL tour_uart_clr_acc k=%0d got=%b exp=0", k, clr_cmd_rdy_UART); end
      tick();
      n_checks++;
      if (resp !== ((k == 47) ? 8'hA5 : 8'h5A)) begin
        n_errors++; $display("FAIL tour_resp k=%0d got=%h exp=%h", k, resp, (k == 47) ? 8'hA5 : 8'h5A);
      end
      respond();
    end
    n_checks++; if (ncmd !== 48) begin n_errors++; $display("FAIL tour_count got=%0d exp=48", ncmd); end
    // back in IDLE: the held-off UART command is now forwarded
    n_checks++; if (cmd !== 16'hBEEF || cmd_rdy !== 1'b1 || resp !== 8'hA5) begin n_errors++; $display("FAIL tour_idle got=%h/%b/%h exp=beef/1/a5", cmd, cmd_rdy, resp); end
    clr_cmd_rdy = 1'b1; #1;
    n_checks++; if (clr_cmd_rdy_UART !== 1'b1) begin n_errors++; $display("FAIL tour_idle_clr got=%b exp=1", clr_cmd_rdy_UART); end
    clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
    // start_tour during a tour is ignored
    start_tour = 1'b1; tick(); start_tour = 1'b0; #1;
    accept(); respond(); accept();
    start_tour = 1'b1; tick(); start_tour = 1'b0; #1;
    n_checks++; if (mv_indx !== 5'd0 || cmd_rdy !== 1'b0 || cmd !== exp_cmd(mem[0], 1'b1)) begin n_errors++; $display("FAIL start_ignored got=%0d/%b/%h exp=0/0/%h", mv_indx, cmd_rdy, cmd, exp_cmd(mem[0], 1'b1)); end
    do_reset();
  endtask

  task automatic test_reset_midtour();
    cmd_rdy_UART = 1'b0; cmd_UART = 16'h0000;
    start_tour = 1'b1; tick(); start_tour = 1'b0; #1;
    for (int m = 0; m < 7; m++) begin accept(); respond(); accept(); respond(); end
    accept(); respond(); accept();
    n_checks++; if (mv_indx !== 5'd7 || cmd !== exp_cmd(mem[7], 1'b1) || cmd_rdy !== 1'b0) begin n_errors++; $display("FAIL pre_reset got=%0d/%h exp=7/%h", mv_indx, cmd, exp_cmd(mem[7], 1'b1)); end
    rst_n = 1'b0; #1;
    n_checks++; if (mv_indx !== 5'd0 || resp !== 8'hA5 || cmd !== 16'h0000 || cmd_rdy !== 1'b0) begin n_errors++; $display("FAIL midreset got=%0d/%h/%h/%b exp=0/a5/0000/0", mv_indx, resp, cmd, cmd_rdy); end
    @(negedge clk); rst_n = 1'b1; tick();
    start_tour = 1'b1; tick(); start_tour = 1'b0; #1;
    n_checks++; if (mv_indx !== 5'd0 || cmd !== exp_cmd(mem[0], 1'b0) || cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL restart got=%0d/%h/%b exp=0/%h/1", mv_indx, cmd, cmd_rdy, exp_cmd(mem[0], 1'b0)); end
  endtask

  initial begin
    rst_n = 1'b0; start_tour = 1'b0; cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    for (int i = 0; i < 24; i++) mem[i] = 8'h00;
    test_reset();
    test_passthrough();
    test_single_moves();
    test_full_tour();
    test_reset_midtour();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_tour_cmd_gen
`default_nettype wire
